pixel_load_ctrl: RTL and testbench

Sequencer that streams one frame of 24-bit pixels out of a 16-bit-wide on-chip RAM through the 16→24 width converter. It issues word reads and paces them against downstream back-pressure. It pads odd pixel counts so the converter's 3-word phase stays aligned across frames, masks the pad pixel, and signals frame completion. It sits between the frame RAM read port and the pixel FIFO feeding the encoder.

---
 rtl/pixel_load_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pixel_load_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_load_ctrl.sv
// Streams one frame of 3-byte pixels from a 2-byte-wide RAM through the 16->24 converter, padding odd counts to whole word triples.
// Build option PIXEL_LOAD_CTRL_ABORT_EN adds i_abort: stop issue, hold the converter in reset for RD_LAT+2 cycles, then done.
module pixel_load_ctrl #(
    parameter int QUAN_BITS = 8,
    parameter int ADDR_W    = 16,
    parameter int RD_LAT    = 2
) (
    input  logic                   s_clk,
    input  logic                   s_rst,
    input  logic                   i_start,
    input  logic [ADDR_W-1:0]      i_base_addr,
    input  logic [15:0]            i_pix_num,
`ifdef PIXEL_LOAD_CTRL_ABORT_EN
    input  logic                   i_abort,
`endif
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_rd_en,
    output logic [ADDR_W-1:0]      o_rd_addr,
    input  logic [2*QUAN_BITS-1:0] i_rd_data,
    output logic [2*QUAN_BITS-1:0] o_wc_bytes,
    output logic                   o_wc_valid,
    output logic                   o_wc_rst,
    input  logic [3*QUAN_BITS-1:0] i_wc_bytes,
    input  logic                   i_wc_valid,
    output logic [3*QUAN_BITS-1:0] o_pix_data,
    output logic                   o_pix_valid,
    input  logic                   i_pix_afull
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef PIXEL_LOAD_CTRL_ABORT_EN
    localparam logic [2:0] ST_FLUSH = 3'd4;
    localparam int FLW = $clog2(RD_LAT + 2);
    localparam logic [FLW-1:0] FLUSH_LAST = FLW'(RD_LAT + 1);
    logic [FLW-1:0] flush_cnt_q, flush_cnt_d;
`endif

    logic [2:0]             state_q, state_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [15:0]            num_q, num_d;
    logic [16:0]            pairs_q, pairs_d;
    logic [17:0]            word_cnt_q, word_cnt_d;
    logic [16:0]            conv_cnt_q, conv_cnt_d;
    logic [RD_LAT-1:0]      vld_sr_q, vld_sr_d;
    logic                   wc_valid_q, wc_valid_d;
    logic [2*QUAN_BITS-1:0] wc_bytes_q, wc_bytes_d;
    logic                   wc_rst_q, wc_rst_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [3*QUAN_BITS-1:0] pix_data_q, pix_data_d;

    logic        start_acc, abort_take, in_frame, rd_en;
    logic [17:0] words_total;

    // Three words per pixel pair; odd N still consumes the full last triple.
    assign words_total = {1'b0, pairs_q} + {pairs_q, 1'b0};

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        pairs_d    = pairs_q;
        word_cnt_d = word_cnt_q;
        conv_cnt_d = conv_cnt_q;
`ifdef PIXEL_LOAD_CTRL_ABORT_EN
        flush_cnt_d = flush_cnt_q;
`endif
        start_acc = (state_q == ST_IDLE) && i_start;
        in_frame  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
`ifdef PIXEL_LOAD_CTRL_ABORT_EN
        abort_take = i_abort && in_frame;
`else
        abort_take = 1'b0;
`endif
        rd_en = (state_q == ST_RUN) && !i_pix_afull && !abort_take;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    base_d     = i_base_addr;
                    num_d      = i_pix_num;
                    pairs_d    = ({1'b0, i_pix_num} + 17'd1) >> 1;
                    word_cnt_d = '0;
                    conv_cnt_d = '0;
                    state_d    = (i_pix_num == 16'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rd_en) begin
                    word_cnt_d = word_cnt_q + 18'd1;
                    if (word_cnt_q == words_total - 18'd1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ({1'b0, conv_cnt_q} == {pairs_q, 1'b0}) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
`ifdef PIXEL_LOAD_CTRL_ABORT_EN
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) state_d = ST_DONE;
                else flush_cnt_d = flush_cnt_q + 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

`ifdef PIXEL_LOAD_CTRL_ABORT_EN
        if (abort_take) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
        end
`endif
        if (in_frame && i_wc_valid) conv_cnt_d = conv_cnt_q + 17'd1;

        vld_sr_d   = RD_LAT'({vld_sr_q, rd_en});
        wc_valid_d = vld_sr_q[RD_LAT-1];
        wc_bytes_d = i_rd_data;
`ifdef PIXEL_LOAD_CTRL_ABORT_EN
        wc_rst_d = start_acc || (state_d == ST_FLUSH);
`else
        wc_rst_d = start_acc;
`endif
        // Converter output index equals conv_cnt before increment; index N is the pad pixel.
        pix_valid_d = i_wc_valid && in_frame && !abort_take && ({1'b0, num_q} > conv_cnt_q);
        pix_data_d  = i_wc_bytes;
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            num_q       <= '0;
            pairs_q     <= '0;
            word_cnt_q  <= '0;
            conv_cnt_q  <= '0;
            vld_sr_q    <= '0;
            wc_valid_q  <= 1'b0;
            wc_bytes_q  <= '0;
            wc_rst_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
`ifdef PIXEL_LOAD_CTRL_ABORT_EN
            flush_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            pairs_q     <= pairs_d;
            word_cnt_q  <= word_cnt_d;
            conv_cnt_q  <= conv_cnt_d;
            vld_sr_q    <= vld_sr_d;
            wc_valid_q  <= wc_valid_d;
            wc_bytes_q  <= wc_bytes_d;
            wc_rst_q    <= wc_rst_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
`ifdef PIXEL_LOAD_CTRL_ABORT_EN
            flush_cnt_q <= flush_cnt_d;
`endif
        end
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);
    assign o_rd_en     = rd_en;
    assign o_rd_addr   = base_q + ADDR_W'(word_cnt_q);
    assign o_wc_bytes  = wc_bytes_q;
    assign o_wc_valid  = wc_valid_q;
    assign o_wc_rst    = wc_rst_q;
    assign o_pix_data  = pix_data_q;
    assign o_pix_valid = pix_valid_q;

endmodule

// File: tb/tb_pixel_load_ctrl.sv
// Bench for pixel_load_ctrl: RAM and 16->24 converter models around the DUT; pixels are predicted from the RAM byte stream.
module tb_pixel_load_ctrl;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        s_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_pix_afull = 1'b0;
    logic [15:0] i_base_addr = '0;
    logic [15:0] i_pix_num = '0;
`ifdef PIXEL_LOAD_CTRL_ABORT_EN
    logic        i_abort = 1'b0;
`endif
    logic        o_busy, o_done, o_rd_en, o_wc_valid, o_wc_rst, o_pix_valid;
    logic [15:0] o_rd_addr, o_wc_bytes;
    logic [15:0] rp0 = '0, rp1 = '0;
    logic [23:0] o_pix_data;
    logic [23:0] cv_bytes = '0;
    logic        cv_valid = 1'b0;
    logic [15:0] cw0 = '0, cw1 = '0;
    logic [1:0]  cph = '0;

    pixel_load_ctrl #(.QUAN_BITS(8), .ADDR_W(16), .RD_LAT(RD_LAT)) dut (
        .s_clk(clk), .s_rst(s_rst), .i_start(i_start),
        .i_base_addr(i_base_addr), .i_pix_num(i_pix_num),
`ifdef PIXEL_LOAD_CTRL_ABORT_EN
        .i_abort(i_abort),
`endif
        .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
        .i_rd_data(rp1), .o_wc_bytes(o_wc_bytes), .o_wc_valid(o_wc_valid), .o_wc_rst(o_wc_rst),
        .i_wc_bytes(cv_bytes), .i_wc_valid(cv_valid),
        .o_pix_data(o_pix_data), .o_pix_valid(o_pix_valid), .i_pix_afull(i_pix_afull)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    function automatic logic [7:0] byte_at(input logic [15:0] b, input int j);
        logic [15:0] w;
        w = mem_word(b + 16'(j / 2));
        return (j % 2 == 1) ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [23:0] pix_model(input logic [15:0] b, input int k);
        return {byte_at(b, 3*k + 2), byte_at(b, 3*k + 1), byte_at(b, 3*k)};
    endfunction

    // RAM: data for an address appears RD_LAT cycles after it is presented.
    always @(posedge clk) begin
        rp0 <= mem_word(o_rd_addr);
        rp1 <= rp0;
    end

    // Converter: low byte of each word first; pixel emitted on 2nd and 3rd word.
    always @(posedge clk) begin
        if (s_rst || o_wc_rst) begin
            cph <= '0;
            cv_valid <= 1'b0;
        end else begin
            cv_valid <= 1'b0;
            if (o_wc_valid) begin
                case (cph)
                    2'd0: begin cw0 <= o_wc_bytes; cph <= 2'd1; end
                    2'd1: begin cv_bytes <= {o_wc_bytes[7:0], cw0}; cw1 <= o_wc_bytes; cv_valid <= 1'b1; cph <= 2'd2; end
                    default: begin cv_bytes <= {o_wc_bytes, cw1[15:8]}; cv_valid <= 1'b1; cph <= 2'd0; end
                endcase
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int rd_n, pix_n, conv_n, busy_n, done_n, wcrst_n, done_cyc, first_rd, first_pix, first_wcrst;
    logic [15:0] exp_addr[$];
    logic [23:0] exp_pix[$];
    logic [23:0] got[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        if (o_rd_en) begin
            rd_n++;
            if (first_rd < 0) first_rd = cyc;
            chk("rd_while_afull", {31'd0, i_pix_afull}, 32'd0);
            if (exp_addr.size() == 0) chk("rd_extra", {16'd0, o_rd_addr}, 32'hFFFF_FFFF);
            else chk("rd_addr", {16'd0, o_rd_addr}, {16'd0, exp_addr.pop_front()});
        end
        if (o_pix_valid) begin
            pix_n++;
            if (first_pix < 0) first_pix = cyc;
            got.push_back(o_pix_data);
            if (exp_pix.size() == 0) chk("pix_extra", {8'd0, o_pix_data}, 32'hFFFF_FFFF);
            else chk("pix_data", {8'd0, o_pix_data}, {8'd0, exp_pix.pop_front()});
        end
        if (cv_valid) conv_n++;
        if (o_busy) busy_n++;
        if (o_wc_rst) begin
            wcrst_n++;
            if (first_wcrst < 0) first_wcrst = cyc;
        end
        if (o_done) begin
            done_n++;
            done_cyc = cyc;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] b, input logic [15:0] n, output int s);
        int p;
        p = (int'(n) + 1) / 2;
        exp_addr.delete(); exp_pix.delete(); got.delete();
        for (int i = 0; i < 3*p; i++) exp_addr.push_back(b + 16'(i));
        for (int k = 0; k < int'(n); k++) exp_pix.push_back(pix_model(b, k));
        rd_n = 0; pix_n = 0; conv_n = 0; busy_n = 0; done_n = 0; wcrst_n = 0;
        done_cyc = -1; first_rd = -1; first_pix = -1; first_wcrst = -1;
        i_start = 1'b1; i_base_addr = b; i_pix_num = n;
        s = cyc;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit tog);
        int tc;
        tc = 0;
        for (int i = 0; i < limit && done_cyc < 0; i++) begin
            if (tog) begin
                tc++;
                if (tc % 3 == 0) i_pix_afull = ~i_pix_afull;
            end
            tick();
        end
        i_pix_afull = 1'b0;
        chk("done_seen", {31'd0, done_cyc >= 0}, 32'd1);
        repeat (3) tick();
    endtask

    task automatic chk_left(input string nm);
        chk(nm, exp_addr.size() + exp_pix.size(), 0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {o_busy, o_done, o_rd_en, o_wc_valid, o_wc_rst, o_pix_valid, o_rd_addr, o_wc_bytes}, 0);
        chk({nm, "_pix_data"}, {8'd0, o_pix_data}, 0);
    endtask

    initial begin
        int s, a, rd0, pix0, wr0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        s_rst = 1'b0;
        repeat (2) tick();

        // Model pinned to hand-computed bytes of RAM words 0x0100..0x0102.
        chk("model_pix0", {8'd0, pix_model(16'h0100, 0)}, 32'h00FE00FF);
        chk("model_pix1", {8'd0, pix_model(16'h0100, 1)}, 32'h0002FD01);

        start_frame(16'h0100, 16'd4, s);
        wait_done(60, 1'b0);
        chk("A_wcrst_cyc", first_wcrst, s + 1);
        chk("A_first_rd", first_rd, s + 1);
        chk("A_first_pix", first_pix, s + RD_LAT + 5);
        chk("A_done_cyc", done_cyc, s + 12);
        chk("A_rd_n", rd_n, 6);
        chk("A_pix_n", pix_n, 4);
        chk("A_busy_n", busy_n, 12);
        chk("A_done_n", done_n, 1);
        chk("A_pix0_lit", {8'd0, got[0]}, 32'h00FE00FF);
        chk("A_pix1_lit", {8'd0, got[1]}, 32'h0002FD01);
        chk_left("A_left");

        start_frame(16'h0200, 16'd3, s);
        wait_done(60, 1'b0);
        chk("odd_rd_n", rd_n, 6);
        chk("odd_conv_n", conv_n, 4);
        chk("odd_pix_n", pix_n, 3);
        chk("odd_done_cyc", done_cyc, s + 6 + RD_LAT + 4);
        chk_left("odd_left");

        start_frame(16'h0300, 16'd2, s);
        wait_done(60, 1'b0);
        chk("after_odd_pix_n", pix_n, 2);
        chk_left("after_odd_left");

        start_frame(16'h0000, 16'd0, s);
        wait_done(20, 1'b0);
        chk("zero_rd_n", rd_n, 0);
        chk("zero_done_cyc", done_cyc, s + 1);
        chk("zero_busy_n", busy_n, 1);

        start_frame(16'h0A00, 16'd8, s);
        wait_done(200, 1'b1);
        chk("afull_rd_n", rd_n, 12);
        chk("afull_pix_n", pix_n, 8);
        chk_left("afull_left");

        start_frame(16'h0400, 16'd4, s);
        while (cyc < s + 5) tick();
        i_start = 1'b1; i_base_addr = 16'h0700; i_pix_num = 16'd10;
        tick();
        i_start = 1'b0;
        while (cyc < s + 12) tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (15) tick();
        chk("busy_start_done_cyc", done_cyc, s + 12);
        chk("busy_start_done_n", done_n, 1);
        chk("busy_start_rd_n", rd_n, 6);
        chk("busy_start_pix_n", pix_n, 4);
        chk("busy_start_busy_n", busy_n, 12);
        chk_left("busy_start_left");

        start_frame(16'h0500, 16'd6, s);
        tick(); tick();
        @(negedge clk);
        chk("pre_rst_rd_en", {31'd0, o_rd_en}, 32'd1);
        s_rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        exp_addr.delete(); exp_pix.delete();
        repeat (3) tick();
        start_frame(16'h0600, 16'd2, s);
        wait_done(60, 1'b0);
        chk("post_rst_pix_n", pix_n, 2);
        chk("post_rst_rd_n", rd_n, 3);
        chk("post_rst_done_cyc", done_cyc, s + 3 + RD_LAT + 4);
        chk_left("post_rst_left");

`ifdef PIXEL_LOAD_CTRL_ABORT_EN
        start_frame(16'h0800, 16'd8, s);
        for (int i = 0; i < 40 && pix_n < 2; i++) tick();
        rd0 = rd_n; pix0 = pix_n; wr0 = wcrst_n; a = cyc;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        wait_done(40, 1'b0);
        chk("abort_pix_before", pix0, 2);
        chk("abort_pix_after", pix_n, pix0);
        chk("abort_rd_after", rd_n, rd0);
        chk("abort_done_cyc", done_cyc, a + RD_LAT + 3);
        chk("abort_wcrst_n", wcrst_n - wr0, RD_LAT + 2);
        exp_addr.delete(); exp_pix.delete();
        start_frame(16'h0900, 16'd2, s);
        wait_done(60, 1'b0);
        chk("post_abort_pix_n", pix_n, 2);
        chk_left("post_abort_left");
`else
        rd0 = 0; pix0 = 0; wr0 = 0; a = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
